bg_fetch_scheduler: RTL and testbench
=====================================

// Module: bg_fetch_scheduler
// PURPOSE
//  Owns the single read port of the background ROM (ROM_WIDTH x 2**ROM_ADDR_BITS, 1-cycle
//  registered read). Converts screen pixel coords into scaled, horizontally scrolled
//  ROM addresses for the display pipe. Shares blanking-time ROM slots with a secondary
//  requester (collision/probe logic) via req/gnt/rvalid.
//  Sits between the VGA timing generator and the background ROM.
// PARAMETERS
//  ROM_WIDTH      12  colour word width (RGB444)
//  ROM_ADDR_BITS  16  ROM address width, = {ty[7:0], tx[7:0]}
//  SCALE_SHIFT    1   screen->texel right shift (1 = 2x2 pixel per texel)
// PORTS
//  clk          in   1              system/pixel clock, all logic on rising edge
//  reset        in   1              synchronous, active-high
//  video_on     in   1              active-display qualifier for x/y
//  x            in   10             screen column
//  y            in   10             screen row
//  frame_start  in   1              1-cycle pulse at start of vertical blank
//  scroll_x     in   8              requested horizontal texel scroll
//  rom_addr     out  ROM_ADDR_BITS  registered ROM address
//  rom_data     in   ROM_WIDTH      ROM output, valid 1 cycle after rom_addr
//  color        out  ROM_WIDTH      background pixel colour to mixer
//  color_valid  out  1              color corresponds to an active pixel
//  sec_req      in   1              secondary read request, held until sec_gnt
//  sec_addr     in   ROM_ADDR_BITS  secondary address, stable while sec_req
//  sec_gnt      out  1              1-cycle pulse: request accepted, may drop sec_req
//  sec_rdata    out  ROM_WIDTH      secondary read data
//  sec_rvalid   out  1              1-cycle pulse: sec_rdata valid
// BEHAVIOUR
//  Reset: rom_addr=0, color=0, color_valid=0, sec_gnt=0, sec_rdata=0, sec_rvalid=0,
//   scroll register=0, FSM=IDLE, valid pipe cleared. Any in-flight secondary read dropped.
//  Scroll: scroll_q <= scroll_x only on cycles with frame_start=1; mid-frame changes ignored.
//  Display lane (has absolute priority): at edge N with video_on=1:
//   tx = (x >> SCALE_SHIFT)[7:0] + scroll_q, mod 256 (wraps, no carry into ty);
//   ty = (y >> SCALE_SHIFT)[7:0]; rom_addr <= {ty, tx}.
//   ROM registers at N+1; at N+2 color <= rom_data, color_valid <= 1. Latency = 2 clocks.
//   For inactive pixels color_valid=0 and color=0 two clocks later (forced black).
//  Secondary lane FSM: IDLE -> ISSUE -> WAIT -> IDLE.
//   IDLE: if sec_req=1 and video_on=0 at edge: rom_addr <= sec_addr, sec_gnt <= 1, ->ISSUE.
//    If video_on=1, request waits (no grant); no timeout, blanking always recurs.
//   ISSUE: sec_gnt <= 0; ROM fetching; ->WAIT.
//   WAIT: sec_rdata <= rom_data, sec_rvalid <= 1 for one cycle, ->IDLE.
//  Port is pipelined: a display address may be issued the cycle after a secondary one;
//   video_on rising in ISSUE/WAIT does not corrupt the secondary result.
//  Simultaneous video_on=1 and sec_req=1: display wins, no grant.
//  Back-to-back secondary: new grant only from IDLE, i.e. max one per 3 cycles.
//  When neither lane issues, rom_addr holds its last value.
//  sec_rdata holds its value between rvalid pulses.
// STRUCTURE
//  Shared package bg_pkg: ROM_WIDTH, ROM_ADDR_BITS, texel coord typedef (8b),
//   secondary FSM state enum {IDLE, ISSUE, WAIT}.
//  One sub-module natural: bg_addr_gen (scale + scroll + concat, registered output).
//  Remaining: scroll register, 2-deep valid pipe, secondary FSM, address mux.
// TESTING
//  1 scroll_x=0, video_on=1, x=10, y=6 at edge N -> rom_addr=0x0305 after N;
//    color=ROM[0x0305], color_valid=1 after N+2.
//  2 frame_start with scroll_x=0xF0, then x=0x1FE (tx=0xFF), y=0 -> rom_addr=0x00EF (wrap);
//    scroll_x change without frame_start -> no address change.
//  3 video_on=0, sec_req=1, sec_addr=0x1234 -> sec_gnt pulse next edge,
//    sec_rvalid pulse 2 edges later with sec_rdata=ROM[0x1234].
//  4 sec_req held while video_on=1 for 100 cycles -> no sec_gnt; grant on first blank cycle;
//    video_on rising during WAIT -> display pixels and sec_rdata both correct.
//  5 reset asserted in ISSUE -> no sec_rvalid ever for that request;
//    all outputs 0 on next cycle; scroll_q=0.
//  6 video_on=0 span -> color=0, color_valid=0 exactly 2 cycles after the fall.

Source files
------------

// File: rtl/bg_fetch_scheduler_pkg.sv
`default_nettype none
// ============================================================================
// Module   : bg_pkg
// Purpose  : Shared constants and types for the background fetch scheduler:
//            ROM geometry, texel coordinate type and the secondary-lane FSM
//            state encoding.
// Ports    : none (package)
// Revision : 1.0  initial release
// ============================================================================
package bg_pkg;

  // Colour word width (RGB444) and ROM address width ({ty, tx}).
  localparam int ROM_WIDTH     = 12;
  localparam int ROM_ADDR_BITS = 16;
  localparam int TEXEL_BITS    = 8;

  // One texel coordinate; arithmetic on it wraps mod 256 by construction.
  typedef logic [TEXEL_BITS-1:0] texel_t;

  // Secondary read lane: grant, ROM fetch, data return.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } sec_state_t;

endpackage : bg_pkg
`default_nettype wire

// File: rtl/bg_fetch_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module   : bg_fetch_scheduler_if
// Purpose  : Request/grant/return-data bundle between the secondary requester
//            (collision/probe logic) and the background fetch scheduler.
// Signals  : req    requester -> scheduler  read request, held until gnt
//            addr   requester -> scheduler  ROM address, stable while req
//            gnt    scheduler -> requester  1-cycle pulse, request accepted
//            rdata  scheduler -> requester  read data, held between rvalids
//            rvalid scheduler -> requester  1-cycle pulse, rdata valid
// Modports : master = requester side, slave = scheduler side
// Revision : 1.0  initial release
// ============================================================================
interface bg_fetch_scheduler_if;

  logic                             req;
  logic [bg_pkg::ROM_ADDR_BITS-1:0] addr;
  logic                             gnt;
  logic [bg_pkg::ROM_WIDTH-1:0]     rdata;
  logic                             rvalid;

  modport master (
    output req,
    output addr,
    input  gnt,
    input  rdata,
    input  rvalid
  );

  modport slave (
    input  req,
    input  addr,
    output gnt,
    output rdata,
    output rvalid
  );

endinterface : bg_fetch_scheduler_if
`default_nettype wire

// File: rtl/bg_fetch_scheduler_addr_gen.sv
`default_nettype none
// ============================================================================
// Module   : bg_addr_gen
// Purpose  : Owns the registered ROM address. Display pixels are scaled down
//            to texels, scrolled horizontally (wrapping inside the row) and
//            concatenated as {ty, tx}; otherwise a secondary address may be
//            loaded; with neither, the address holds.
// Ports    : clk       in   clock
//            reset     in   synchronous active-high reset
//            video_on  in   display lane active this cycle (top priority)
//            x, y      in   screen coordinates (10 b)
//            scroll    in   frame-stable horizontal texel scroll
//            sec_load  in   load sec_addr this cycle
//            sec_addr  in   secondary ROM address
//            rom_addr  out  registered ROM address
// Revision : 1.0  initial release
// ============================================================================
module bg_addr_gen
  import bg_pkg::*;
#(
  parameter int SCALE_SHIFT = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     video_on,
  input  logic [9:0]               x,
  input  logic [9:0]               y,
  input  texel_t                   scroll,
  input  logic                     sec_load,
  input  logic [ROM_ADDR_BITS-1:0] sec_addr,
  output logic [ROM_ADDR_BITS-1:0] rom_addr
);

  texel_t tx;
  texel_t ty;

  // The texel-sized cast drops the scaled coordinate's upper bits; the 8-bit
  // add then wraps tx without carrying into ty.
  assign tx = texel_t'(x >> SCALE_SHIFT) + scroll;
  assign ty = texel_t'(y >> SCALE_SHIFT);

  always_ff @(posedge clk) begin
    if (reset) begin
      rom_addr <= '0;
    end else if (video_on) begin
      rom_addr <= {ty, tx};
    end else if (sec_load) begin
      rom_addr <= sec_addr;
    end
  end

endmodule : bg_addr_gen
`default_nettype wire

// File: rtl/bg_fetch_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : bg_fetch_scheduler
// Purpose  : Single-port background ROM scheduler. The display lane converts
//            screen coordinates to ROM addresses and returns colour two clocks
//            later; a secondary requester is served in blanking time through
//            a req/gnt/rvalid handshake. The display always wins the port.
// Ports    : clk          in   system/pixel clock
//            reset        in   synchronous active-high reset
//            video_on     in   active-display qualifier for x/y
//            x, y         in   screen column / row (10 b)
//            frame_start  in   1-cycle pulse at start of vertical blank
//            scroll_x     in   requested horizontal texel scroll
//            rom_addr     out  registered ROM address
//            rom_data     in   ROM output, valid 1 cycle after rom_addr
//            color        out  background colour (0 for inactive pixels)
//            color_valid  out  color belongs to an active pixel
//            sec          if   secondary requester handshake (slave side)
// Revision : 1.0  initial release
// ============================================================================
module bg_fetch_scheduler
  import bg_pkg::*;
#(
  parameter int SCALE_SHIFT = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     video_on,
  input  logic [9:0]               x,
  input  logic [9:0]               y,
  input  logic                     frame_start,
  input  logic [7:0]               scroll_x,
  output logic [ROM_ADDR_BITS-1:0] rom_addr,
  input  logic [ROM_WIDTH-1:0]     rom_data,
  output logic [ROM_WIDTH-1:0]     color,
  output logic                     color_valid,
  bg_fetch_scheduler_if.slave      sec
);

  texel_t     scroll_q;
  logic [1:0] vld_pipe;     // [0]: address issued, [1]: ROM data present
  sec_state_t state;
  sec_state_t state_n;
  logic       sec_load;
  logic       gnt_n;
  logic       rvalid_n;

  // --------------------------------------------------------------------------
  // Address generation and shared-port mux
  // --------------------------------------------------------------------------
  bg_addr_gen #(
    .SCALE_SHIFT (SCALE_SHIFT)
  ) u_addr_gen (
    .clk      (clk),
    .reset    (reset),
    .video_on (video_on),
    .x        (x),
    .y        (y),
    .scroll   (scroll_q),
    .sec_load (sec_load),
    .sec_addr (sec.addr),
    .rom_addr (rom_addr)
  );

  // --------------------------------------------------------------------------
  // Scroll register and display return path
  // --------------------------------------------------------------------------
  // Scroll is only sampled at frame start so a whole frame uses one offset.
  always_ff @(posedge clk) begin
    if (reset) begin
      scroll_q    <= '0;
      vld_pipe    <= '0;
      color       <= '0;
      color_valid <= 1'b0;
    end else begin
      if (frame_start) begin
        scroll_q <= scroll_x;
      end
      vld_pipe    <= {vld_pipe[0], video_on};
      color_valid <= vld_pipe[1];
      // Blanked pixels are forced black; rom_data may be secondary data then.
      color       <= vld_pipe[1] ? rom_data : '0;
    end
  end

  // --------------------------------------------------------------------------
  // Secondary lane FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  // A grant is only possible from IDLE, which bounds secondary traffic to one
  // read every three cycles and keeps the return slot unambiguous.
  always_comb begin
    state_n  = state;
    sec_load = 1'b0;
    gnt_n    = 1'b0;
    rvalid_n = 1'b0;
    case (state)
      IDLE: begin
        if (sec.req && !video_on) begin
          sec_load = 1'b1;
          gnt_n    = 1'b1;
          state_n  = ISSUE;
        end
      end
      ISSUE: begin
        state_n = WAIT;
      end
      WAIT: begin
        rvalid_n = 1'b1;
        state_n  = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // In WAIT the ROM output still holds the secondary word even if the display
  // lane has issued a new address at the previous edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      sec.gnt    <= 1'b0;
      sec.rvalid <= 1'b0;
      sec.rdata  <= '0;
    end else begin
      sec.gnt    <= gnt_n;
      sec.rvalid <= rvalid_n;
      if (rvalid_n) begin
        sec.rdata <= rom_data;
      end
    end
  end

endmodule : bg_fetch_scheduler
`default_nettype wire

// File: tb/tb_bg_fetch_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_bg_fetch_scheduler
// Purpose  : Self-checking bench for bg_fetch_scheduler with a behavioural
//            1-cycle registered ROM and a display-colour scoreboard.
// Revision : 1.0  initial release
// ============================================================================
module tb_bg_fetch_scheduler;

  logic        clk = 1'b0;
  logic        reset;
  logic        video_on;
  logic [9:0]  x;
  logic [9:0]  y;
  logic        frame_start;
  logic [7:0]  scroll_x;
  logic [15:0] rom_addr;
  logic [11:0] rom_data = '0;
  logic [11:0] color;
  logic        color_valid;

  bg_fetch_scheduler_if sec_if ();

  bg_fetch_scheduler #(
    .SCALE_SHIFT (1)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .video_on    (video_on),
    .x           (x),
    .y           (y),
    .frame_start (frame_start),
    .scroll_x    (scroll_x),
    .rom_addr    (rom_addr),
    .rom_data    (rom_data),
    .color       (color),
    .color_valid (color_valid),
    .sec         (sec_if)
  );

  always #5 clk = ~clk;

  // Known ROM contents: a cheap hash that is nonzero at address 0.
  function automatic logic [11:0] rom_fn(input logic [15:0] a);
    return a[11:0] ^ {a[15:12], a[15:8]} ^ 12'h5A3;
  endfunction

  always @(posedge clk) rom_data <= rom_fn(rom_addr);

  typedef struct {
    logic        v;
    logic [11:0] c;
  } px_t;

  px_t         disp_q[$];
  logic [11:0] sec_q[$];
  logic [7:0]  m_scroll;
  int          n_vec = 0;
  int          n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] disp_addr(input logic [9:0] px, input logic [9:0] py,
                                            input logic [7:0] s);
    logic [9:0] sx;
    logic [9:0] sy;
    logic [7:0] tx;
    sx = px >> 1;
    sy = py >> 1;
    tx = sx[7:0] + s;
    return {sy[7:0], tx};
  endfunction

  // One clock: record the expected pixel for the inputs now applied, clock,
  // check the display address and the pixel that is due two clocks later.
  task automatic step();
    logic [15:0] ea;
    logic        ev;
    px_t         p;
    ev = video_on;
    ea = disp_addr(x, y, m_scroll);
    p.v = ev;
    p.c = ev ? rom_fn(ea) : 12'h000;
    disp_q.push_back(p);
    if (frame_start) m_scroll = scroll_x;
    @(posedge clk);
    #1;
    if (ev) chk("rom_addr_disp", {16'h0, rom_addr}, {16'h0, ea});
    if (disp_q.size() == 3) begin
      p = disp_q.pop_front();
      chk("color_valid", {31'h0, color_valid}, {31'h0, p.v});
      chk("color", {20'h0, color}, {20'h0, p.c});
    end
  endtask

  task automatic do_reset();
    px_t z;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    chk("rst_rom_addr", {16'h0, rom_addr}, 32'h0);
    chk("rst_color", {20'h0, color}, 32'h0);
    chk("rst_color_valid", {31'h0, color_valid}, 32'h0);
    chk("rst_gnt", {31'h0, sec_if.gnt}, 32'h0);
    chk("rst_rvalid", {31'h0, sec_if.rvalid}, 32'h0);
    chk("rst_rdata", {20'h0, sec_if.rdata}, 32'h0);
    m_scroll = 8'h00;
    disp_q.delete();
    sec_q.delete();
    z.v = 1'b0;
    z.c = 12'h000;
    disp_q.push_back(z);
    disp_q.push_back(z);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [11:0] exp_d;
    reset       = 1'b1;
    video_on    = 1'b0;
    x           = '0;
    y           = '0;
    frame_start = 1'b0;
    scroll_x    = '0;
    sec_if.req  = 1'b0;
    sec_if.addr = '0;
    m_scroll    = '0;
    @(posedge clk);
    do_reset();

    // Basic display fetch, scroll 0.
    video_on = 1'b1; x = 10'd10; y = 10'd6;
    step();
    chk("t1_addr", {16'h0, rom_addr}, 32'h0305);
    for (int i = 0; i < 8; i++) begin
      x = 10'(100 + 3 * i);
      y = 10'(50 + i);
      step();
    end
    video_on = 1'b0;
    step(); step(); step();

    // Scroll load at frame start and horizontal wrap.
    frame_start = 1'b1; scroll_x = 8'hF0;
    step();
    frame_start = 1'b0;
    video_on = 1'b1; x = 10'h1FE; y = 10'd0;
    step();
    chk("t2_wrap", {16'h0, rom_addr}, 32'h00EF);
    scroll_x = 8'h33;
    step();
    chk("t2_no_reload", {16'h0, rom_addr}, 32'h00EF);
    x = 10'd40; y = 10'd300;
    step();
    // Fall of video_on: colour stays valid one more clock, then black.
    video_on = 1'b0;
    step(); step(); step(); step();

    // Single secondary read in blanking.
    sec_if.req = 1'b1; sec_if.addr = 16'h1234;
    sec_q.push_back(rom_fn(16'h1234));
    step();
    chk("t3_gnt", {31'h0, sec_if.gnt}, 32'h1);
    chk("t3_addr", {16'h0, rom_addr}, 32'h1234);
    chk("t3_rvalid_early", {31'h0, sec_if.rvalid}, 32'h0);
    sec_if.req = 1'b0;
    step();
    chk("t3_gnt_drop", {31'h0, sec_if.gnt}, 32'h0);
    chk("t3_rvalid_mid", {31'h0, sec_if.rvalid}, 32'h0);
    step();
    exp_d = sec_q.pop_front();
    chk("t3_rvalid", {31'h0, sec_if.rvalid}, 32'h1);
    chk("t3_rdata", {20'h0, sec_if.rdata}, {20'h0, exp_d});
    step();
    chk("t3_rvalid_end", {31'h0, sec_if.rvalid}, 32'h0);
    chk("t3_rdata_hold", {20'h0, sec_if.rdata}, {20'h0, exp_d});

    // Back-to-back requests: at most one grant per three cycles.
    sec_if.req = 1'b1; sec_if.addr = 16'h0042;
    for (int i = 0; i < 6; i++) begin
      step();
      chk("b2b_gnt", {31'h0, sec_if.gnt}, {31'h0, (i % 3) == 0});
      chk("b2b_rvalid", {31'h0, sec_if.rvalid}, {31'h0, (i % 3) == 2});
      if (i == 0) sec_if.addr = 16'h0043;
      if (i == 2) chk("b2b_rdata0", {20'h0, sec_if.rdata}, {20'h0, rom_fn(16'h0042)});
      if (i == 5) chk("b2b_rdata1", {20'h0, sec_if.rdata}, {20'h0, rom_fn(16'h0043)});
    end
    sec_if.req = 1'b0;
    step();

    // Request starved by active video, granted at first blank cycle,
    // video resumes while the read is in flight.
    sec_if.req = 1'b1; sec_if.addr = 16'hBEEF;
    sec_q.push_back(rom_fn(16'hBEEF));
    video_on = 1'b1; y = 10'd20;
    for (int i = 0; i < 100; i++) begin
      x = 10'(i * 5);
      step();
      chk("t4_no_gnt", {31'h0, sec_if.gnt}, 32'h0);
    end
    video_on = 1'b0;
    step();
    chk("t4_gnt", {31'h0, sec_if.gnt}, 32'h1);
    chk("t4_addr", {16'h0, rom_addr}, 32'hBEEF);
    sec_if.req = 1'b0;
    step();
    chk("t4_rvalid_mid", {31'h0, sec_if.rvalid}, 32'h0);
    video_on = 1'b1; x = 10'd7; y = 10'd9;
    step();
    exp_d = sec_q.pop_front();
    chk("t4_rvalid", {31'h0, sec_if.rvalid}, 32'h1);
    chk("t4_rdata", {20'h0, sec_if.rdata}, {20'h0, exp_d});
    for (int i = 0; i < 4; i++) begin
      x = 10'(200 + i);
      step();
    end
    video_on = 1'b0;
    step(); step(); step();

    // Reset while a secondary read is in ISSUE.
    frame_start = 1'b1; scroll_x = 8'h40;
    step();
    frame_start = 1'b0;
    sec_if.req = 1'b1; sec_if.addr = 16'h0777;
    step();
    chk("t5_gnt", {31'h0, sec_if.gnt}, 32'h1);
    sec_if.req = 1'b0;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      step();
      chk("t5_no_rvalid", {31'h0, sec_if.rvalid}, 32'h0);
    end
    video_on = 1'b1; x = 10'd20; y = 10'd2;
    step();
    chk("t5_scroll_clear", {16'h0, rom_addr}, 32'h010A);
    video_on = 1'b0;
    step(); step(); step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_bg_fetch_scheduler
`default_nettype wire
